ysyx_22040750_ifu: RTL and testbench
====================================

// Module: ysyx_22040750_ifu
// PURPOSE
//  Instruction-fetch stage sitting directly downstream of the next-PC generator. Owns the architectural PC register.
//  - Accepts dnpc from the next-PC generator over a valid/ready handshake.
//  - Issues one instruction fetch at a time on a req/rsp imem bus.
//  - Presents {pc, snpc, inst} to ID through the IF_ID valid/ready handshake.
//  - Handles a redirect flush (trap/interrupt) with drain of any in-flight fetch.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset
//  NOP_INST   32'h0000_0013  instruction substituted on a misaligned fetch (see CONFIGURATION)
// PORTS
//  I_clk              in   1   clock; all state updates on posedge
//  I_rst_n            in   1   reset, asynchronous assert, active-low
//  I_dnpc             in   32  next PC from the next-PC generator
//  I_dnpc_valid       in   1   I_dnpc valid
//  O_dnpc_ready       out  1   IFU can take I_dnpc this cycle
//  I_flush            in   1   redirect request, highest priority
//  I_flush_pc         in   32  redirect target
//  O_imem_req_valid   out  1   fetch request
//  O_imem_addr        out  32  fetch address; word aligned, [1:0]=0
//  I_imem_req_ready   in   1   request accepted
//  I_imem_rsp_valid   in   1   response valid; one cycle per request
//  I_imem_rsp_data    in   32  fetched instruction
//  O_IF_ID_valid      out  1   IF_ID payload valid
//  I_ID_ready         in   1   ID accepts payload
//  O_IF_ID_pc         out  32  PC of the instruction
//  O_IF_ID_snpc       out  32  pc+4
//  O_IF_ID_inst       out  32  instruction
//  O_IF_ID_misalign   out  1   pc[1:0]!=0 (macro only; otherwise tied 0)
// BEHAVIOUR
//  - Reset (async, I_rst_n=0) values:
//    - pc=RESET_PC, state=REQ, flush_pend=0.
//    - Outputs O_imem_req_valid, O_IF_ID_valid, O_dnpc_ready, O_IF_ID_misalign all 0.
//    - O_IF_ID_pc, O_IF_ID_snpc, O_IF_ID_inst all 0.
//  - O_imem_req_valid rises the first clock edge after reset release.
//  - States: REQ, WAIT, HOLD, NEXT, DRAIN.
//  - REQ:
//    - O_imem_req_valid=1, O_imem_addr=pc.
//    - Address stays stable until I_imem_req_ready.
//    - On accept: go to WAIT, or to DRAIN if flush_pend or I_flush is set.
//  - WAIT:
//    - On I_imem_rsp_valid: latch inst, drive O_IF_ID_valid=1 next cycle, go to HOLD.
//    - Response latency is unbounded; a response may arrive the cycle after accept.
//  - HOLD:
//    - O_IF_ID_valid=1; payload held stable while !I_ID_ready.
//    - On I_ID_ready: go to NEXT.
//  - NEXT:
//    - O_dnpc_ready=1.
//    - On I_dnpc_valid: pc<=I_dnpc, go to REQ.
//  - HOLD with I_ID_ready && I_dnpc_valid in the same cycle: O_dnpc_ready=1, pc<=I_dnpc, go straight to REQ (one-cycle fast path).
//  - O_dnpc_ready = (state==NEXT) | (state==HOLD & I_ID_ready).
//  - DRAIN: discard the next I_imem_rsp_valid (no IF_ID valid), then go to REQ at pc.
//  - Flush (I_flush=1), per state:
//    - REQ, not accepted: pc_pend<=I_flush_pc, flush_pend<=1, request stays stable. When it is accepted: DRAIN, and pc<=pc_pend.
//    - REQ, accepted in the same cycle: pc<=I_flush_pc, go to DRAIN.
//    - WAIT without rsp: pc<=I_flush_pc, go to DRAIN.
//    - WAIT with rsp in the same cycle: response dropped, pc<=I_flush_pc, go to REQ.
//    - HOLD/NEXT: O_IF_ID_valid deasserts next cycle, any dnpc this cycle is ignored, pc<=I_flush_pc, go to REQ.
//  - Flush wins over every simultaneous handshake. A second flush while already in DRAIN only updates pc.
//  - Arithmetic: snpc = pc + 32'd4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
//  - Reset mid-fetch: state returns to REQ at RESET_PC. A stale response arriving after reset, with no request outstanding, is ignored.
//  - At most one request outstanding at any time.
// CONFIGURATION
//  IFU_MISALIGN_CHK_EN
//   - Defined:
//     - On entering REQ with pc[1:0]!=0, no bus request is issued.
//     - Next cycle goes to HOLD with O_IF_ID_misalign=1 and O_IF_ID_inst=NOP_INST, so ID raises the exception.
//     - Flush rules are unchanged.
//   - Undefined:
//     - O_imem_addr = {pc[31:2],2'b00}.
//     - O_IF_ID_misalign tied 0.
//     - O_IF_ID_pc still reports the full pc.
// TESTING
//  T1 reset:
//   - Stimulus: hold I_rst_n=0 3 cycles, release.
//   - Response: req_valid=1, addr=8000_0000. req_ready=1, rsp 0000_0093 after 2 cycles.
//     Then IF_ID_valid=1, pc=8000_0000, snpc=8000_0004, inst=0000_0093.
//  T2 backpressure:
//   - Stimulus: I_ID_ready=0 for 5 cycles.
//   - Response: payload stable, O_dnpc_ready=0. I_ID_ready=1 with I_dnpc_valid=1, dnpc=8000_0010,
//     then next cycle req addr=8000_0010.
//  T3 flush in WAIT:
//   - Stimulus: flush_pc=8000_0100 while WAIT.
//   - Response: the old rsp is dropped (no IF_ID_valid). Next request addr=8000_0100.
//  T4 flush in REQ while req_ready=0:
//   - Stimulus: flush_pc=8000_0200.
//   - Response: addr held at the old value until accept. The following rsp is discarded.
//     Then req addr=8000_0200.
//  T5 flush in HOLD with I_ID_ready=1 and I_dnpc_valid=1 (dnpc=8000_0020), flush_pc=8000_0300:
//   - Response: dnpc ignored, IF_ID_valid=0 next cycle, next req addr=8000_0300.
//  T6 macro on, dnpc=8000_0002:
//   - Response: no req_valid. IF_ID_valid=1, misalign=1, inst=0000_0013.
//   - Macro off: addr=8000_0000, misalign=0.

Source files
------------

// File: rtl/ysyx_22040750_ifu.sv
// ysyx_22040750_ifu: instruction fetch stage owning the architectural PC.
// Optional IFU_MISALIGN_CHK_EN turns misaligned fetches into a NOP with a misalign flag.
module ysyx_22040750_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [31:0] I_dnpc,
    input  logic        I_dnpc_valid,
    output logic        O_dnpc_ready,
    input  logic        I_flush,
    input  logic [31:0] I_flush_pc,
    output logic        O_imem_req_valid,
    output logic [31:0] O_imem_addr,
    input  logic        I_imem_req_ready,
    input  logic        I_imem_rsp_valid,
    input  logic [31:0] I_imem_rsp_data,
    output logic        O_IF_ID_valid,
    input  logic        I_ID_ready,
    output logic [31:0] O_IF_ID_pc,
    output logic [31:0] O_IF_ID_snpc,
    output logic [31:0] O_IF_ID_inst,
    output logic        O_IF_ID_misalign
);
    typedef enum logic [2:0] {REQ, WAIT, HOLD, NEXT, DRAIN} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, pend_pc, pend_pc_n;
    logic        live, pend, pend_n, cap, cap_mis, mis, accept;
`ifdef IFU_MISALIGN_CHK_EN
    assign mis         = live && pc[1:0] != 2'b00;
    assign O_imem_addr = pc;
`else
    assign mis         = 1'b0;
    assign O_imem_addr = {pc[31:2], 2'b00};
`endif
    // live holds off the first request until one edge after reset release
    assign O_imem_req_valid = live && state == REQ && !mis;
    assign accept           = O_imem_req_valid && I_imem_req_ready;
    assign O_IF_ID_valid    = state == HOLD;
    assign O_dnpc_ready     = state == NEXT || (state == HOLD && I_ID_ready);
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        pend_n    = pend;
        pend_pc_n = pend_pc;
        cap       = 1'b0;
        cap_mis   = 1'b0;
        case (state)
            REQ: begin
                if (mis) begin
                    pc_n    = I_flush ? I_flush_pc : pc;
                    cap_mis = !I_flush;
                    state_n = I_flush ? REQ : HOLD;
                end else if (accept) begin
                    state_n = (I_flush || pend) ? DRAIN : WAIT;
                    pc_n    = I_flush ? I_flush_pc : pend ? pend_pc : pc;
                    pend_n  = 1'b0;
                end else if (I_flush) begin
                    pend_pc_n = I_flush_pc;
                    pend_n    = 1'b1;
                end
            end
            WAIT: begin
                if (I_flush) begin
                    pc_n    = I_flush_pc;
                    state_n = I_imem_rsp_valid ? REQ : DRAIN;
                end else if (I_imem_rsp_valid) begin
                    cap     = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (I_flush) begin
                    pc_n    = I_flush_pc;
                    state_n = REQ;
                end else if (I_ID_ready) begin
                    pc_n    = I_dnpc_valid ? I_dnpc : pc;
                    state_n = I_dnpc_valid ? REQ : NEXT;
                end
            end
            NEXT: begin
                pc_n    = I_flush ? I_flush_pc : I_dnpc_valid ? I_dnpc : pc;
                state_n = (I_flush || I_dnpc_valid) ? REQ : NEXT;
            end
            DRAIN: begin
                pc_n    = I_flush ? I_flush_pc : pc;
                state_n = I_imem_rsp_valid ? REQ : DRAIN;
            end
            default: state_n = REQ;
        endcase
    end
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state            <= REQ;
            live             <= 1'b0;
            pc               <= RESET_PC;
            pend             <= 1'b0;
            pend_pc          <= 32'h0;
            O_IF_ID_pc       <= 32'h0;
            O_IF_ID_snpc     <= 32'h0;
            O_IF_ID_inst     <= 32'h0;
            O_IF_ID_misalign <= 1'b0;
        end else begin
            state   <= state_n;
            live    <= 1'b1;
            pc      <= pc_n;
            pend    <= pend_n;
            pend_pc <= pend_pc_n;
            if (cap || cap_mis) begin
                O_IF_ID_pc       <= pc;
                O_IF_ID_snpc     <= pc + 32'd4;
                O_IF_ID_inst     <= cap ? I_imem_rsp_data : NOP_INST;
                O_IF_ID_misalign <= cap_mis;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// tb_ysyx_22040750_ifu: directed bench with a payload scoreboard for the fetch stage.
module tb_ysyx_22040750_ifu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] dnpc = '0, flush_pc = '0, rsp_data = '0;
    logic        dnpc_valid = 1'b0, flush = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0, id_ready = 1'b0;
    logic        dnpc_ready, req_valid, if_valid, misalign;
    logic [31:0] addr, if_pc, if_snpc, if_inst;
    int          checks = 0, fails = 0;
    typedef struct {logic [31:0] pc, snpc, inst; logic mis;} exp_t;
    exp_t q[$];

    ysyx_22040750_ifu dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_dnpc(dnpc), .I_dnpc_valid(dnpc_valid),
        .O_dnpc_ready(dnpc_ready), .I_flush(flush), .I_flush_pc(flush_pc),
        .O_imem_req_valid(req_valid), .O_imem_addr(addr), .I_imem_req_ready(req_ready),
        .I_imem_rsp_valid(rsp_valid), .I_imem_rsp_data(rsp_data), .O_IF_ID_valid(if_valid),
        .I_ID_ready(id_ready), .O_IF_ID_pc(if_pc), .O_IF_ID_snpc(if_snpc),
        .O_IF_ID_inst(if_inst), .O_IF_ID_misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic mis);
        exp_t e;
        e.pc = pc; e.snpc = pc + 32'd4; e.inst = inst; e.mis = mis;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        for (int i = 0; i < 20 && !if_valid; i++) step();
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        if (if_valid && q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_pc"}, if_pc, e.pc);
            chk({tag, "_snpc"}, if_snpc, e.snpc);
            chk({tag, "_inst"}, if_inst, e.inst);
            chk({tag, "_mis"}, {31'd0, misalign}, {31'd0, e.mis});
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst, input string tag);
        chk({tag, "_addr"}, addr, pc);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = inst;
        push(pc, inst, 1'b0);
        step();
        rsp_valid = 1'b0;
        pop_cmp(tag);
    endtask

    task automatic take(input logic [31:0] npc);
        id_ready = 1'b1; dnpc_valid = 1'b1; dnpc = npc;
        step();
        id_ready = 1'b0; dnpc_valid = 1'b0;
    endtask

    initial begin
        // T1 reset
        #1;
        repeat (3) step();
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_dnpc_ready", {31'd0, dnpc_ready}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_snpc", if_snpc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        rst_n = 1'b1;
        chk("rel_req_valid", {31'd0, req_valid}, 32'd0);
        step();
        chk("t1_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t1_addr", addr, 32'h8000_0000);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("t1_wait_req", {31'd0, req_valid}, 32'd0);
        step();
        rsp_valid = 1'b1; rsp_data = 32'h0000_0093;
        push(32'h8000_0000, 32'h0000_0093, 1'b0);
        step();
        rsp_valid = 1'b0;
        pop_cmp("t1");
        // T2 backpressure
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_valid", {31'd0, if_valid}, 32'd1);
            chk("t2_hold_pc", if_pc, 32'h8000_0000);
            chk("t2_hold_inst", if_inst, 32'h0000_0093);
            chk("t2_dnpc_ready", {31'd0, dnpc_ready}, 32'd0);
        end
        id_ready = 1'b1; dnpc_valid = 1'b1; dnpc = 32'h8000_0010;
        #1;
        chk("t2_fast_ready", {31'd0, dnpc_ready}, 32'd1);
        step();
        id_ready = 1'b0; dnpc_valid = 1'b0;
        chk("t2_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t2_addr", addr, 32'h8000_0010);
        chk("t2_if_valid", {31'd0, if_valid}, 32'd0);
        // T3 flush in WAIT
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h8000_0100;
        step();
        flush = 1'b0;
        chk("t3_drain_req", {31'd0, req_valid}, 32'd0);
        rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        step();
        rsp_valid = 1'b0;
        chk("t3_dropped", {31'd0, if_valid}, 32'd0);
        chk("t3_req_valid", {31'd0, req_valid}, 32'd1);
        fetch(32'h8000_0100, 32'h0000_0113, "t3");
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("next_dnpc_ready", {31'd0, dnpc_ready}, 32'd1);
        chk("next_if_valid", {31'd0, if_valid}, 32'd0);
        dnpc_valid = 1'b1; dnpc = 32'h8000_0040;
        step();
        dnpc_valid = 1'b0;
        // T4 flush in REQ while not accepted
        chk("t4_pre_addr", addr, 32'h8000_0040);
        flush = 1'b1; flush_pc = 32'h8000_0200;
        step();
        flush = 1'b0;
        chk("t4_held_valid", {31'd0, req_valid}, 32'd1);
        chk("t4_held_addr", addr, 32'h8000_0040);
        step();
        chk("t4_held_addr2", addr, 32'h8000_0040);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("t4_drain_req", {31'd0, req_valid}, 32'd0);
        rsp_valid = 1'b1; rsp_data = 32'hBAD0_0000;
        step();
        rsp_valid = 1'b0;
        chk("t4_dropped", {31'd0, if_valid}, 32'd0);
        chk("t4_req_valid", {31'd0, req_valid}, 32'd1);
        fetch(32'h8000_0200, 32'h0000_0213, "t4");
        // T5 flush beats the HOLD fast path
        id_ready = 1'b1; dnpc_valid = 1'b1; dnpc = 32'h8000_0020;
        flush = 1'b1; flush_pc = 32'h8000_0300;
        step();
        id_ready = 1'b0; dnpc_valid = 1'b0; flush = 1'b0;
        chk("t5_if_valid", {31'd0, if_valid}, 32'd0);
        chk("t5_req_valid", {31'd0, req_valid}, 32'd1);
        fetch(32'h8000_0300, 32'h0000_0313, "t5");
        // snpc wraps at the top of the address space
        take(32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0000_0413, "wrap");
        // T6 misaligned dnpc
        take(32'h8000_0002);
`ifdef IFU_MISALIGN_CHK_EN
        chk("t6_no_req", {31'd0, req_valid}, 32'd0);
        push(32'h8000_0002, 32'h0000_0013, 1'b1);
        step();
        chk("t6_no_req2", {31'd0, req_valid}, 32'd0);
        pop_cmp("t6");
`else
        chk("t6_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t6_addr", addr, 32'h8000_0000);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'h0000_0513;
        push(32'h8000_0002, 32'h0000_0513, 1'b0);
        step();
        rsp_valid = 1'b0;
        pop_cmp("t6");
`endif
        // asynchronous reset while holding a payload, then a stale response
        #2 rst_n = 1'b0;
        #1;
        chk("ar_if_valid", {31'd0, if_valid}, 32'd0);
        chk("ar_pc", if_pc, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("ar_req_valid", {31'd0, req_valid}, 32'd1);
        chk("ar_addr", addr, 32'h8000_0000);
        rsp_valid = 1'b1; rsp_data = 32'hFACE_FACE;
        step();
        rsp_valid = 1'b0;
        chk("ar_stale_valid", {31'd0, if_valid}, 32'd0);
        chk("ar_stale_req", {31'd0, req_valid}, 32'd1);
        chk("ar_stale_addr", addr, 32'h8000_0000);
        chk("sb_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
